wb_data_serializer: RTL and testbench
=====================================

// Module: wb_data_serializer
// PURPOSE
//  Sequential Wishbone width adapter: one mdw-bit master access becomes one or more sdw-bit slave beats.
//  Any wbm_sel_i pattern is accepted; unaligned and multi-lane accesses are serialised, not rejected.
//  Read beats are assembled into a registered wbm_dat_o. Sits between wb_intercon and narrow peripherals (UART, SPI, flash).
//  Big-endian lane order: lane 0 (lowest slave address) maps to wbm_dat_i[mdw-1 -: sdw].
// PARAMETERS
//  aw      32   address width
//  mdw     32   master data width; mdw = sdw * 2^k, 1<=k<=3
//  sdw     8    slave data width; 8, 16 or 32
//  tmo     255  slave-beat watchdog limit in cycles (used only with WB_DATA_SERIALIZER_TIMEOUT_EN)
// PORTS
//  wb_clk_i   in   1        clock
//  wb_rst_i   in   1        reset, asynchronous, active-high
//  wbm_adr_i  in   aw       master address
//  wbm_dat_i  in   mdw      master write data
//  wbm_sel_i  in   mdw/8    master byte selects
//  wbm_we_i / wbm_cyc_i / wbm_stb_i   in  1   master control
//  wbm_cti_i  in   3        ignored (bursts handled as classic)
//  wbm_bte_i  in   2        ignored
//  wbm_dat_o  out  mdw      assembled read data (registered)
//  wbm_ack_o / wbm_err_o / wbm_rty_o  out 1   master termination, one-cycle pulses
//  wbs_adr_o  out  aw       slave address
//  wbs_dat_o  out  sdw      slave write data
//  wbs_sel_o  out  sdw/8    slave byte selects
//  wbs_we_o / wbs_cyc_o / wbs_stb_o   out 1   slave control
//  wbs_cti_o  out  3        constant 3'b000
//  wbs_bte_o  out  2        constant 2'b00
//  wbs_dat_i  in   sdw      slave read data
//  wbs_ack_i / wbs_err_i / wbs_rty_i  in  1   slave termination
// BEHAVIOUR
//  Reset (async, wb_rst_i=1): state IDLE; all outputs 0 (wbm_dat_o, wbs_* included).
//  Lanes: N=mdw/sdw; lane i active iff |wbm_sel_i[bits of lane i]; wbs_sel_o = those sel bits.
//  wbs_adr_o = {wbm_adr_i[aw-1:log2(mdw/8)], i*(sdw/8)} (byte address of lane i).
//  FSM: IDLE -> BEAT -> DONE -> IDLE; all outputs registered.
//  IDLE: on wbm_cyc_i&wbm_stb_i: latch adr/dat/sel/we, clear wbm_dat_o; no active lane -> DONE with err;
//   otherwise load lowest active lane, enter BEAT.
//  BEAT: wbs_cyc_o=wbs_stb_o=1. On wbs_ack_i: read -> write wbs_dat_i into lane slot; advance to next active
//   lane (next cycle, stb held high) or go DONE with ack once the last active lane completes.
//   Inactive lanes are skipped with zero cycles.
//  wbs_err_i / wbs_rty_i in BEAT: abort remaining lanes; DONE with err / rty respectively.
//   Simultaneous ack+err: err wins.
//  DONE: wbs_cyc_o=wbs_stb_o=0; exactly one of wbm_ack_o/wbm_err_o/wbm_rty_o high for one cycle; then IDLE.
//  Latency, zero-wait slave: M active lanes -> wbm_ack_o in cycle M+1 after request is sampled; +1 idle cycle before the next request.
//  wbm_cyc_i dropped in BEAT: abort without master termination; IDLE next cycle; wbs_cyc_o/stb_o drop next cycle.
//  wbm_dat_o: unselected lanes read 0; valid from the DONE cycle and held until the next accepted request.
//  sdw==mdw is not supported (use the pass-through instead).
// CONFIGURATION
//  WB_DATA_SERIALIZER_TIMEOUT_EN defined: counter reset on each beat start; tmo cycles in BEAT without
//   ack/err/rty -> abort, wbs_cyc_o low, DONE with wbm_err_o.
//  Not defined: no counter; BEAT waits indefinitely; tmo unused.
// TESTING (mdw=32, sdw=8 unless noted)
//  1 Read adr 0x100 sel 1111, zero-wait slave returns 11,22,33,44 -> wbs_adr_o 0x100..0x103 in 4 consecutive
//    cycles, wbm_ack_o in cycle 5, wbm_dat_o=0x11223344.
//  2 Write adr 0x200 sel 0101 dat 0xAABBCCDD -> exactly 2 beats: (0x201,0xBB) then (0x203,0xDD); one ack.
//  3 sel 0000 -> wbm_err_o pulse, wbs_cyc_o never asserted; sdw=16, sel 0110 -> beats 0x..0 sel 01, 0x..2 sel 10.
//  4 Read sel 1111, slave err on beat 2 -> no beat 3, single wbm_err_o pulse, no wbm_ack_o.
//  5 wb_rst_i pulsed mid-beat (async, between clock edges) -> all outputs 0 immediately; next request completes normally.
//  6 TIMEOUT_EN, tmo=16, silent slave -> wbm_err_o 16 cycles after beat start; without macro, still waiting at 1000 cycles.

Source files
------------

// File: rtl/wb_data_serializer.sv
// Wishbone width adapter: one mdw-bit master access becomes one beat per active sdw-bit lane.
// Optional slave-beat watchdog enabled by defining WB_DATA_SERIALIZER_TIMEOUT_EN.
module wb_data_serializer #(
  parameter int unsigned aw  = 32,
  parameter int unsigned mdw = 32,
  parameter int unsigned sdw = 8,
  parameter int unsigned tmo = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [aw-1:0]     wbm_adr_i,
  input  logic [mdw-1:0]    wbm_dat_i,
  input  logic [mdw/8-1:0]  wbm_sel_i,
  input  logic              wbm_we_i,
  input  logic              wbm_cyc_i,
  input  logic              wbm_stb_i,
  input  logic [2:0]        wbm_cti_i,
  input  logic [1:0]        wbm_bte_i,
  output logic [mdw-1:0]    wbm_dat_o,
  output logic              wbm_ack_o,
  output logic              wbm_err_o,
  output logic              wbm_rty_o,
  output logic [aw-1:0]     wbs_adr_o,
  output logic [sdw-1:0]    wbs_dat_o,
  output logic [sdw/8-1:0]  wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  input  logic [sdw-1:0]    wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i
);

  localparam int unsigned N  = mdw / sdw;
  localparam int unsigned SB = sdw / 8;
  localparam int unsigned MB = mdw / 8;
  localparam int unsigned OW = $clog2(MB);
  localparam int unsigned LW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t             state;
  logic [aw-OW-1:0]   adr_q;
  logic [mdw-1:0]     dat_q;
  logic [MB-1:0]      sel_q;
  logic [N-1:0]       mask_q;
  logic               we_q;
  logic [LW-1:0]      lane_q;

  logic [N-1:0]       req_mask;
  logic [LW-1:0]      req_first;
  logic [N-1:0]       rem_mask;
  logic [LW-1:0]      rem_next;
  logic               rem_any;

  logic unused_ok;
  assign unused_ok = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[OW-1:0]};

  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

  // Lane 0 is the most significant slot of the master word.
  function automatic logic [sdw-1:0] lane_dat(input logic [mdw-1:0] d, input logic [LW-1:0] l);
    logic [mdw-1:0] t;
    t = d << (l * sdw);
    return t[mdw-1 -: sdw];
  endfunction

  function automatic logic [SB-1:0] lane_sel(input logic [MB-1:0] s, input logic [LW-1:0] l);
    logic [MB-1:0] t;
    t = s << (l * SB);
    return t[MB-1 -: SB];
  endfunction

  function automatic logic [aw-1:0] lane_adr(input logic [aw-OW-1:0] hi, input logic [LW-1:0] l);
    return {hi, OW'(l * SB)};
  endfunction

  // Active-lane masks and lowest-active-lane search for a new request and for the remaining lanes.
  always_comb begin
    req_mask  = '0;
    rem_mask  = '0;
    req_first = '0;
    rem_next  = '0;
    for (int i = 0; i < int'(N); i++) begin
      req_mask[i] = |wbm_sel_i[MB-1-i*SB -: SB];
      rem_mask[i] = mask_q[i] && (LW'(i) > lane_q);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_mask[i]) req_first = LW'(i);
      if (rem_mask[i]) rem_next  = LW'(i);
    end
    rem_any = |rem_mask;
  end

`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(tmo + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TW'(tmo - 1));
`else
  localparam int unsigned unused_tmo = tmo;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      mask_q    <= '0;
      we_q      <= 1'b0;
      lane_q    <= '0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            adr_q     <= wbm_adr_i[aw-1:OW];
            dat_q     <= wbm_dat_i;
            sel_q     <= wbm_sel_i;
            mask_q    <= req_mask;
            we_q      <= wbm_we_i;
            wbm_dat_o <= '0;
            if (req_mask == '0) begin
              state     <= DONE;
              wbm_err_o <= 1'b1;
            end else begin
              state     <= BEAT;
              lane_q    <= req_first;
              wbs_adr_o <= lane_adr(wbm_adr_i[aw-1:OW], req_first);
              wbs_dat_o <= lane_dat(wbm_dat_i, req_first);
              wbs_sel_o <= lane_sel(wbm_sel_i, req_first);
              wbs_we_o  <= wbm_we_i;
              wbs_cyc_o <= 1'b1;
              wbs_stb_o <= 1'b1;
`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        BEAT: begin
          // Master abandoning the cycle ends the access silently.
          if (!wbm_cyc_i) begin
            state     <= IDLE;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
          end else if (wbs_err_i) begin
            state     <= DONE;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_err_o <= 1'b1;
          end else if (wbs_rty_i) begin
            state     <= DONE;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_rty_o <= 1'b1;
          end else if (wbs_ack_i) begin
            if (!we_q) begin
              for (int i = 0; i < int'(N); i++) begin
                if (LW'(i) == lane_q) wbm_dat_o[mdw-1-i*sdw -: sdw] <= wbs_dat_i;
              end
            end
            if (rem_any) begin
              lane_q    <= rem_next;
              wbs_adr_o <= lane_adr(adr_q, rem_next);
              wbs_dat_o <= lane_dat(dat_q, rem_next);
              wbs_sel_o <= lane_sel(sel_q, rem_next);
`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              state     <= DONE;
              wbs_cyc_o <= 1'b0;
              wbs_stb_o <= 1'b0;
              wbm_ack_o <= 1'b1;
            end
          end
`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
          else if (tmo_hit) begin
            state     <= DONE;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbm_err_o <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_serializer.sv
// Directed bench for wb_data_serializer: 32->8 instance with scripted slave, plus a 32->16 instance.
module tb_wb_data_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_stb, m_cyc8, m_cyc16;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;

  logic [31:0] d8_dat_o, s8_adr;
  logic        d8_ack, d8_err, d8_rty;
  logic [7:0]  s8_dat_o, s8_dat_i;
  logic [0:0]  s8_sel;
  logic        s8_we, s8_cyc, s8_stb, s8_ack, s8_err, s8_rty;
  logic [2:0]  s8_cti;
  logic [1:0]  s8_bte;

  logic [31:0] d16_dat_o, s16_adr;
  logic        d16_ack, d16_err, d16_rty;
  logic [15:0] s16_dat_o, s16_dat_i;
  logic [1:0]  s16_sel;
  logic        s16_we, s16_cyc, s16_stb, s16_ack, s16_err, s16_rty;
  logic [2:0]  s16_cti;
  logic [1:0]  s16_bte;

  wb_data_serializer #(.aw(32), .mdw(32), .sdw(8), .tmo(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc8), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(d8_dat_o), .wbm_ack_o(d8_ack), .wbm_err_o(d8_err), .wbm_rty_o(d8_rty),
    .wbs_adr_o(s8_adr), .wbs_dat_o(s8_dat_o), .wbs_sel_o(s8_sel), .wbs_we_o(s8_we),
    .wbs_cyc_o(s8_cyc), .wbs_stb_o(s8_stb), .wbs_cti_o(s8_cti), .wbs_bte_o(s8_bte),
    .wbs_dat_i(s8_dat_i), .wbs_ack_i(s8_ack), .wbs_err_i(s8_err), .wbs_rty_i(s8_rty)
  );

  wb_data_serializer #(.aw(32), .mdw(32), .sdw(16), .tmo(16)) u_dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc16), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(d16_dat_o), .wbm_ack_o(d16_ack), .wbm_err_o(d16_err), .wbm_rty_o(d16_rty),
    .wbs_adr_o(s16_adr), .wbs_dat_o(s16_dat_o), .wbs_sel_o(s16_sel), .wbs_we_o(s16_we),
    .wbs_cyc_o(s16_cyc), .wbs_stb_o(s16_stb), .wbs_cti_o(s16_cti), .wbs_bte_o(s16_bte),
    .wbs_dat_i(s16_dat_i), .wbs_ack_i(s16_ack), .wbs_err_i(s16_err), .wbs_rty_i(s16_rty)
  );

  // Slave models: mode 0 zero-wait ack, 1 silent, 2 err on beat err_idx, 3 rty.
  int          mode;
  int          err_idx;
  logic [7:0]  mem [4];
  int          st8_n, l8_n, l16_n, cyc_ctr;
  logic [31:0] l8_adr [64];
  logic [7:0]  l8_dat [64];
  logic        l8_we  [64];
  int          l8_cyc [64];
  logic [31:0] l16_adr [16];
  logic [15:0] l16_dat [16];
  logic [1:0]  l16_sel [16];

  assign s8_dat_i = mem[s8_adr[1:0]];
  assign s8_ack   = s8_cyc & s8_stb & ((mode == 0) || (mode == 2 && st8_n != err_idx));
  assign s8_err   = s8_cyc & s8_stb & (mode == 2) & (st8_n == err_idx);
  assign s8_rty   = s8_cyc & s8_stb & (mode == 3);
  assign s16_dat_i = 16'h0000;
  assign s16_ack   = s16_cyc & s16_stb;
  assign s16_err   = 1'b0;
  assign s16_rty   = 1'b0;

  initial begin
    st8_n = 0; l8_n = 0; l16_n = 0; cyc_ctr = 0;
  end

  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (s8_cyc && s8_stb) begin
      st8_n <= st8_n + 1;
      if (s8_ack && l8_n < 64) begin
        l8_adr[l8_n] <= s8_adr;
        l8_dat[l8_n] <= s8_dat_o;
        l8_we[l8_n]  <= s8_we;
        l8_cyc[l8_n] <= cyc_ctr;
        l8_n <= l8_n + 1;
      end
    end
    if (s16_cyc && s16_stb && s16_ack && l16_n < 16) begin
      l16_adr[l16_n] <= s16_adr;
      l16_dat[l16_n] <= s16_dat_o;
      l16_sel[l16_n] <= s16_sel;
      l16_n <= l16_n + 1;
    end
  end

  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last transfer.
  int          term, cyc_n, npulse;
  logic [31:0] rd_dat;
  logic        cyc_at_term, cyc_held, cyc_after;

  task automatic xfer(input bit d16, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we, input int bound);
    logic a, e, r;
    term = 0; cyc_n = 0; npulse = 0; rd_dat = '0; cyc_at_term = 1'b0;
    @(negedge clk);
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_stb = 1'b1;
    m_cyc8 = !d16; m_cyc16 = d16;
    for (int i = 1; i <= bound && term == 0; i++) begin
      @(negedge clk);
      a = d16 ? d16_ack : d8_ack;
      e = d16 ? d16_err : d8_err;
      r = d16 ? d16_rty : d8_rty;
      if (a || e || r) begin
        npulse      = int'(a) + int'(e) + int'(r);
        term        = e ? 2 : (r ? 3 : 1);
        cyc_n       = i;
        rd_dat      = d16 ? d16_dat_o : d8_dat_o;
        cyc_at_term = d16 ? s16_cyc : s8_cyc;
      end
    end
    cyc_held = d16 ? s16_cyc : s8_cyc;
    m_stb = 1'b0; m_cyc8 = 1'b0; m_cyc16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) cyc_after = d16 ? s16_cyc : s8_cyc;
      npulse += d16 ? int'(d16_ack) + int'(d16_err) + int'(d16_rty)
                    : int'(d8_ack) + int'(d8_err) + int'(d8_rty);
    end
  endtask

  function automatic logic [127:0] outs8();
    return 128'({d8_dat_o, d8_ack, d8_err, d8_rty, s8_adr, s8_dat_o, s8_sel,
                 s8_we, s8_cyc, s8_stb, s8_cti, s8_bte});
  endfunction

  int b, st0;

  initial begin
    n_cmp = 0; n_bad = 0;
    mode = 0; err_idx = -1;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_stb = 1'b0;
    m_cyc8 = 1'b0; m_cyc16 = 1'b0; m_cti = 3'b111; m_bte = 2'b11;
    rst = 1'b1;
    #1;
    chk("reset_outs", outs8(), 128'h0);
    chk("reset_dat16", 128'(d16_dat_o), 128'h0);
    #13 rst = 1'b0;

    // Full-word read from a zero-wait slave.
    b = l8_n;
    xfer(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 50);
    chk("rd4_term", 128'(term), 128'd1);
    chk("rd4_cycles", 128'(cyc_n), 128'd5);
    chk("rd4_dat", 128'(rd_dat), 128'h11223344);
    chk("rd4_pulses", 128'(npulse), 128'd1);
    chk("rd4_cyc_low", 128'(cyc_at_term), 128'd0);
    chk("rd4_beats", 128'(l8_n - b), 128'd4);
    chk("rd4_adr", {32'(l8_adr[b]), 32'(l8_adr[b+1]), 32'(l8_adr[b+2]), 32'(l8_adr[b+3])},
        {32'h100, 32'h101, 32'h102, 32'h103});
    chk("rd4_consec", 128'(l8_cyc[b+3] - l8_cyc[b]), 128'd3);
    chk("rd4_we", 128'({l8_we[b], l8_we[b+3]}), 128'd0);

    // Sparse write: lanes 1 and 3 only.
    b = l8_n;
    xfer(1'b0, 32'h200, 32'hAABBCCDD, 4'b0101, 1'b1, 50);
    chk("wr2_term", 128'(term), 128'd1);
    chk("wr2_cycles", 128'(cyc_n), 128'd3);
    chk("wr2_beats", 128'(l8_n - b), 128'd2);
    chk("wr2_beat0", {l8_adr[b], l8_dat[b], 7'd0, l8_we[b]}, {32'h201, 8'hBB, 8'h01});
    chk("wr2_beat1", {l8_adr[b+1], l8_dat[b+1]}, {32'h203, 8'hDD});

    // Sparse read: unselected lanes read as zero.
    xfer(1'b0, 32'h10, 32'h0, 4'b1001, 1'b0, 50);
    chk("rd2_term", 128'(term), 128'd1);
    chk("rd2_cycles", 128'(cyc_n), 128'd3);
    chk("rd2_dat", 128'(rd_dat), 128'h11000044);

    // No byte selected: immediate error, slave untouched.
    st0 = st8_n;
    xfer(1'b0, 32'h40, 32'h0, 4'b0000, 1'b0, 50);
    chk("sel0_term", 128'(term), 128'd2);
    chk("sel0_cycles", 128'(cyc_n), 128'd1);
    chk("sel0_nostb", 128'(st8_n - st0), 128'd0);
    chk("sel0_dat", 128'(rd_dat), 128'h0);

    // 16-bit slave, middle two bytes selected.
    b = l16_n;
    xfer(1'b1, 32'h300, 32'h12345678, 4'b0110, 1'b1, 50);
    chk("w16_term", 128'(term), 128'd1);
    chk("w16_cycles", 128'(cyc_n), 128'd3);
    chk("w16_beats", 128'(l16_n - b), 128'd2);
    chk("w16_beat0", {l16_adr[b], l16_dat[b], l16_sel[b]}, {32'h300, 16'h1234, 2'b01});
    chk("w16_beat1", {l16_adr[b+1], l16_dat[b+1], l16_sel[b+1]}, {32'h302, 16'h5678, 2'b10});

    // Slave error on the second beat aborts the rest.
    mode = 2; err_idx = st8_n + 1; st0 = st8_n; b = l8_n;
    xfer(1'b0, 32'h100, 32'h0, 4'b1111, 1'b0, 50);
    chk("err_term", 128'(term), 128'd2);
    chk("err_cycles", 128'(cyc_n), 128'd3);
    chk("err_pulses", 128'(npulse), 128'd1);
    chk("err_stbs", 128'(st8_n - st0), 128'd2);
    chk("err_acks", 128'(l8_n - b), 128'd1);

    // Slave retry on the first beat.
    mode = 3;
    xfer(1'b0, 32'h100, 32'h0, 4'b1111, 1'b1, 50);
    chk("rty_term", 128'(term), 128'd3);
    chk("rty_cycles", 128'(cyc_n), 128'd2);

    // Silent slave: watchdog error, or an indefinite wait aborted by dropping cyc.
    mode = 1;
`ifdef WB_DATA_SERIALIZER_TIMEOUT_EN
    xfer(1'b0, 32'h100, 32'h0, 4'b0001, 1'b0, 100);
    chk("tmo_term", 128'(term), 128'd2);
    chk("tmo_cycles", 128'(cyc_n), 128'd17);
    chk("tmo_cyc_low", 128'(cyc_at_term), 128'd0);
`else
    xfer(1'b0, 32'h100, 32'h0, 4'b0001, 1'b0, 1000);
    chk("wait_term", 128'(term), 128'd0);
    chk("wait_cyc_held", 128'(cyc_held), 128'd1);
    chk("wait_cyc_drop", 128'(cyc_after), 128'd0);
    chk("wait_pulses", 128'(npulse), 128'd0);
`endif

    // Asynchronous reset between clock edges in the middle of a beat.
    @(negedge clk);
    m_adr = 32'h100; m_sel = 4'b1111; m_we = 1'b0; m_stb = 1'b1; m_cyc8 = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_busy", 128'(s8_cyc), 128'd1);
    #2 rst = 1'b1; m_stb = 1'b0; m_cyc8 = 1'b0;
    #1 chk("arst_outs", outs8(), 128'h0);
    #1 rst = 1'b0;
    mode = 0;
    xfer(1'b0, 32'h104, 32'h0, 4'b1111, 1'b0, 50);
    chk("arst_term", 128'(term), 128'd1);
    chk("arst_cycles", 128'(cyc_n), 128'd5);
    chk("arst_dat", 128'(rd_dat), 128'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
